// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of memory_top's single command interface.
// Defining MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the data port has fixed priority.
module mem_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_rd_enable,
    output logic                  mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic       grant_if;
    logic       lat_we;
    logic [7:0] wait_cnt;
    logic       pick_if;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;  // 1: fetch port wins the next tie

    always_comb begin
        pick_if = if_req && (!d_req || rr_ptr);
    end
`else
    always_comb begin
        pick_if = if_req && !d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant_if      <= 1'b0;
            lat_we        <= 1'b0;
            wait_cnt      <= '0;
            if_ack        <= 1'b0;
            if_err        <= 1'b0;
            if_rdata      <= '0;
            d_ack         <= 1'b0;
            d_err         <= 1'b0;
            d_rdata       <= '0;
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if ((if_req || d_req) && !mem_busy) begin
                        grant_if      <= pick_if;
                        lat_we        <= !pick_if && d_we;
                        mem_addr      <= pick_if ? if_addr : d_addr;
                        mem_wr_data   <= pick_if ? '0 : d_wdata;
                        mem_wr_enable <= !pick_if && d_we;
                        mem_rd_enable <= pick_if || !d_we;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rd_enable <= 1'b0;
                    mem_wr_enable <= 1'b0;
                    wait_cnt      <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (!mem_busy) begin
                        // Only the granted port's result registers are loaded; the other stays 0.
                        if (grant_if) begin
                            if_ack   <= 1'b1;
                            if_err   <= 1'b0;
                            if_rdata <= mem_rd_data;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= lat_we ? '0 : mem_rd_data;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == TIMEOUT_LAST) begin
                            if (grant_if) begin
                                if_ack   <= 1'b1;
                                if_err   <= 1'b1;
                                if_rdata <= '0;
                            end else begin
                                d_ack   <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if_ack   <= 1'b0;
                    if_err   <= 1'b0;
                    if_rdata <= '0;
                    d_ack    <= 1'b0;
                    d_err    <= 1'b0;
                    d_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
                    rr_ptr   <= !grant_if;
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES=10); inputs change and outputs are sampled on negedge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [7:0]  if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [7:0]  d_rdata;
    logic        mem_rd_enable;
    logic        mem_wr_enable;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_busy;
    logic [7:0]  mem_rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .if_err(if_err),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_err(d_err),
        .d_rdata(d_rdata),
        .mem_rd_enable(mem_rd_enable),
        .mem_wr_enable(mem_wr_enable),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_busy(mem_busy),
        .mem_rd_data(mem_rd_data)
    );

    task automatic test_reset();
        logic [63:0] outs;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_busy = 1'b0; mem_rd_data = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            outs = {if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
                    mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data};
            checks++;
            if (outs !== 64'(0)) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_rd_enable, mem_wr_enable, if_ack, d_ack} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_no_strobe: got %b expected 0000",
                         {mem_rd_enable, mem_wr_enable, if_ack, d_ack});
            end
        end
    endtask

    task automatic test_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 8'hA5; mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_wr_enable, mem_rd_enable, mem_addr, mem_wr_data} !== {2'b10, 16'h0200, 8'hA5}) begin
            errors++;
            $display("FAIL write_strobe: got wr=%b rd=%b addr=%h data=%h expected wr=1 rd=0 addr=0200 data=a5",
                     mem_wr_enable, mem_rd_enable, mem_addr, mem_wr_data);
        end
        @(negedge clk);
        checks++;
        if ({mem_wr_enable, d_ack} !== 2'b00) begin
            errors++;
            $display("FAIL write_single_pulse: got wr=%b ack=%b expected 0 0", mem_wr_enable, d_ack);
        end
        @(negedge clk);
        checks++;
        if ({d_ack, d_err, if_ack} !== 3'b100) begin
            errors++;
            $display("FAIL write_ack_n3: got ack=%b err=%b if_ack=%b expected 1 0 0", d_ack, d_err, if_ack);
        end
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (d_ack !== 1'b0) begin
            errors++;
            $display("FAIL write_ack_one_cycle: got %b expected 0", d_ack);
        end
    endtask

    task automatic test_read_busy();
        if_req = 1'b1; if_addr = 16'hFFFC; mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_rd_enable, mem_wr_enable, mem_addr} !== {2'b10, 16'hFFFC}) begin
            errors++;
            $display("FAIL read_strobe: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=fffc",
                     mem_rd_enable, mem_wr_enable, mem_addr);
        end
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({if_ack, mem_rd_enable} !== 2'b00) begin
                errors++;
                $display("FAIL read_wait_%0d: got ack=%b rd=%b expected 0 0", i, if_ack, mem_rd_enable);
            end
        end
        mem_busy = 1'b0; mem_rd_data = 8'h34;
        @(negedge clk);
        checks++;
        if ({if_ack, if_err, if_rdata, d_ack, d_rdata} !== {2'b10, 8'h34, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL read_ack: got ack=%b err=%b rdata=%h d_ack=%b d_rdata=%h expected 1 0 34 0 00",
                     if_ack, if_err, if_rdata, d_ack, d_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_ack, if_rdata} !== 9'h000) begin
            errors++;
            $display("FAIL read_ack_clear: got ack=%b rdata=%h expected 0 00", if_ack, if_rdata);
        end
    endtask

    task automatic test_busy_hold();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1234; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_rd_enable, mem_wr_enable} !== 2'b00) begin
                errors++;
                $display("FAIL busy_hold_%0d: got rd=%b wr=%b expected 0 0", i, mem_rd_enable, mem_wr_enable);
            end
        end
        mem_busy = 1'b0; mem_rd_data = 8'h77;
        @(negedge clk);
        checks++;
        if ({mem_rd_enable, mem_addr} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL busy_release_strobe: got rd=%b addr=%h expected 1 1234", mem_rd_enable, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({d_ack, d_err, d_rdata} !== {2'b10, 8'h77}) begin
            errors++;
            $display("FAIL busy_release_ack: got ack=%b err=%b rdata=%h expected 1 0 77", d_ack, d_err, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        if_req = 1'b1; if_addr = 16'h0040; mem_rd_data = 8'h9C;
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({if_ack, if_rdata, d_ack, d_rdata} !== {1'b1, 8'h9C, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL drop_req_ack: got ack=%b rdata=%h d_ack=%b d_rdata=%h expected 1 9c 0 00",
                     if_ack, if_rdata, d_ack, d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_if;
        bit         got;
`ifdef MEM_ARB_RR_EN
        exp_if = 4'b1010;
`else
        exp_if = 4'b0000;
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        mem_busy = 1'b0; mem_rd_data = 8'h5A;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int t = 0; t < 12; t++) begin
                @(negedge clk);
                if (if_ack && d_ack) begin
                    checks++; errors++;
                    $display("FAIL arb_both_acks txn %0d: got both acks high expected one", n);
                end
                if (if_ack || d_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL arb_timeout txn %0d: got no ack expected ack", n);
            end else if ({if_ack, d_ack} !== {exp_if[n], !exp_if[n]}) begin
                errors++;
                $display("FAIL arb_order txn %0d: got if_ack=%b d_ack=%b expected %b %b",
                         n, if_ack, d_ack, exp_if[n], !exp_if[n]);
            end
            checks++;
            if ((exp_if[n] ? {if_rdata, d_rdata} : {d_rdata, if_rdata}) !== {8'h5A, 8'h00}) begin
                errors++;
                $display("FAIL arb_rdata txn %0d: got if_rdata=%h d_rdata=%h expected granted 5a other 00",
                         n, if_rdata, d_rdata);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500; mem_rd_data = 8'hFF; mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_rd_enable !== 1'b1) begin
            errors++;
            $display("FAIL timeout_strobe: got %b expected 1", mem_rd_enable);
        end
        mem_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (d_ack !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early_ack wait %0d: got 1 expected 0", i);
            end
        end
        @(negedge clk);
        checks++;
        if ({d_ack, d_err, d_rdata, if_ack} !== {2'b11, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h if_ack=%b expected 1 1 00 0",
                     d_ack, d_err, d_rdata, if_ack);
        end
        d_req = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_ack, d_err} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_err_clear: got ack=%b err=%b expected 0 0", d_ack, d_err);
        end
    endtask

    task automatic test_reset_in_wait();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0600; mem_busy = 1'b0;
        @(negedge clk);
        mem_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; d_req = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({d_ack, if_ack, mem_rd_enable, mem_wr_enable} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_abort cycle %0d: got %b expected 0000",
                         i, {d_ack, if_ack, mem_rd_enable, mem_wr_enable});
            end
            @(negedge clk);
        end
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0700; d_wdata = 8'h3C;
        @(negedge clk);
        checks++;
        if ({mem_wr_enable, mem_addr, mem_wr_data} !== {1'b1, 16'h0700, 8'h3C}) begin
            errors++;
            $display("FAIL post_reset_strobe: got wr=%b addr=%h data=%h expected 1 0700 3c",
                     mem_wr_enable, mem_addr, mem_wr_data);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({d_ack, d_err} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset_ack: got ack=%b err=%b expected 1 0", d_ack, d_err);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_busy();
        test_busy_hold();
        test_drop_req();
        test_arbitration();
        test_timeout();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
